mem_port_arbiter: RTL and testbench

//  Memory-side responder for the pipelined CPU's split imem/dmem ports. Accepts held requests on both ports,

---
 rtl/mem_arb_pkg.sv | 32 +++
 rtl/mem_arb_perf_ctr.sv | 22 ++
 rtl/mem_port_arbiter.sv | 144 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the split imem/dmem to single pmem port arbiter.
// MEM_ARB_PERF_EN (optional) enables the per-port wait counters sized by PERF_W.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } arb_grant_t;

  localparam int PERF_W = 32;

  // Round-robin pick: a lone requester wins, a tie goes to the port not served last.
  function automatic arb_grant_t pick_grant(input logic i_req,
                                            input logic d_req,
                                            input arb_grant_t last_served);
    arb_grant_t g;
    case ({i_req, d_req})
      2'b10:   g = GNT_I;
      2'b01:   g = GNT_D;
      2'b11:   g = (last_served == GNT_I) ? GNT_D : GNT_I;
      default: g = last_served;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/mem_arb_perf_ctr.sv
// Saturating wait-cycle counter; only instantiated when MEM_ARB_PERF_EN is defined.
module mem_arb_perf_ctr
  import mem_arb_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              inc,
  output logic [PERF_W-1:0] count
);

  // Count up on inc, sticking at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= {PERF_W{1'b0}};
    end else if (inc && (count != {PERF_W{1'b1}})) begin
      count <= count + {{(PERF_W-1){1'b0}}, 1'b1};
    end else begin
      count <= count;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the CPU imem/dmem request ports onto one pmem word port (IDLE->BUSY->RESP).
// Optional MEM_ARB_PERF_EN adds perf_imem_wait/perf_dmem_wait wait-cycle counters.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int MASK_W = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              imem_read,
  input  logic [ADDR_W-1:0] imem_address,
  output logic              imem_resp,
  output logic [DATA_W-1:0] imem_rdata,
  input  logic              dmem_read,
  input  logic              dmem_write,
  input  logic [MASK_W-1:0] dmem_wmask,
  input  logic [ADDR_W-1:0] dmem_address,
  input  logic [DATA_W-1:0] dmem_wdata,
  output logic              dmem_resp,
  output logic [DATA_W-1:0] dmem_rdata,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [DATA_W-1:0] pmem_wdata,
  output logic [MASK_W-1:0] pmem_wmask,
  input  logic              pmem_resp,
  input  logic [DATA_W-1:0] pmem_rdata
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [PERF_W-1:0] perf_imem_wait,
  output logic [PERF_W-1:0] perf_dmem_wait
`endif
);

  arb_state_t state_r;
  arb_grant_t grant_r;
  arb_grant_t last_served_r;
  arb_grant_t next_grant_s;
  logic       i_req_s;
  logic       d_req_s;

  // Request decode and round-robin grant selection for the IDLE state.
  always_comb begin
    i_req_s      = imem_read;
    d_req_s      = dmem_read | dmem_write;
    next_grant_s = pick_grant(i_req_s, d_req_s, last_served_r);
  end

  // Transaction FSM; every port-facing output is a register written here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= IDLE;
      grant_r       <= GNT_I;
      last_served_r <= GNT_I;
      imem_resp     <= 1'b0;
      dmem_resp     <= 1'b0;
      imem_rdata    <= {DATA_W{1'b0}};
      dmem_rdata    <= {DATA_W{1'b0}};
      pmem_read     <= 1'b0;
      pmem_write    <= 1'b0;
      pmem_address  <= {ADDR_W{1'b0}};
      pmem_wdata    <= {DATA_W{1'b0}};
      pmem_wmask    <= {MASK_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          imem_resp <= 1'b0;
          dmem_resp <= 1'b0;
          if (i_req_s || d_req_s) begin
            grant_r <= next_grant_s;
            state_r <= BUSY;
            if (next_grant_s == GNT_D) begin
              // A simultaneous read+write request is carried out as a write.
              pmem_address <= dmem_address;
              pmem_wdata   <= dmem_wdata;
              pmem_wmask   <= dmem_write ? dmem_wmask : {MASK_W{1'b1}};
              pmem_write   <= dmem_write;
              pmem_read    <= ~dmem_write;
            end else begin
              pmem_address <= imem_address;
              pmem_wmask   <= {MASK_W{1'b1}};
              pmem_write   <= 1'b0;
              pmem_read    <= 1'b1;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        BUSY: begin
          if (pmem_resp) begin
            pmem_read     <= 1'b0;
            pmem_write    <= 1'b0;
            last_served_r <= grant_r;
            state_r       <= RESP;
            if (grant_r == GNT_I) begin
              imem_resp  <= 1'b1;
              imem_rdata <= pmem_rdata;
            end else begin
              dmem_resp <= 1'b1;
              if (pmem_read) begin
                dmem_rdata <= pmem_rdata;
              end else begin
                dmem_rdata <= dmem_rdata;
              end
            end
          end else begin
            state_r <= BUSY;
          end
        end
        RESP: begin
          imem_resp <= 1'b0;
          dmem_resp <= 1'b0;
          state_r   <= IDLE;
        end
        default: begin
          imem_resp  <= 1'b0;
          dmem_resp  <= 1'b0;
          pmem_read  <= 1'b0;
          pmem_write <= 1'b0;
          state_r    <= IDLE;
        end
      endcase
    end
  end

`ifdef MEM_ARB_PERF_EN
  mem_arb_perf_ctr u_perf_imem (
    .clk   (clk),
    .rst   (rst),
    .inc   (i_req_s & ~imem_resp),
    .count (perf_imem_wait)
  );

  mem_arb_perf_ctr u_perf_dmem (
    .clk   (clk),
    .rst   (rst),
    .inc   (d_req_s & ~dmem_resp),
    .count (perf_dmem_wait)
  );
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed cases plus randomized rounds against
// a transaction-level model (round-robin winner, latched request, captured read data).
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst;
  logic        imem_read;
  logic [31:0] imem_address;
  logic        imem_resp;
  logic [31:0] imem_rdata;
  logic        dmem_read;
  logic        dmem_write;
  logic [3:0]  dmem_wmask;
  logic [31:0] dmem_address;
  logic [31:0] dmem_wdata;
  logic        dmem_resp;
  logic [31:0] dmem_rdata;
  logic        pmem_read;
  logic        pmem_write;
  logic [31:0] pmem_address;
  logic [31:0] pmem_wdata;
  logic [3:0]  pmem_wmask;
  logic        pmem_resp;
  logic [31:0] pmem_rdata;
`ifdef MEM_ARB_PERF_EN
  logic [31:0] perf_imem_wait;
  logic [31:0] perf_dmem_wait;
`endif

  int checks   = 0;
  int failures = 0;

  // Model state: which port was served last (1 = dmem) and the expected read-data registers.
  bit          last_d;
  logic [31:0] exp_irdata;
  logic [31:0] exp_drdata;

  mem_port_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .imem_read    (imem_read),
    .imem_address (imem_address),
    .imem_resp    (imem_resp),
    .imem_rdata   (imem_rdata),
    .dmem_read    (dmem_read),
    .dmem_write   (dmem_write),
    .dmem_wmask   (dmem_wmask),
    .dmem_address (dmem_address),
    .dmem_wdata   (dmem_wdata),
    .dmem_resp    (dmem_resp),
    .dmem_rdata   (dmem_rdata),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_address (pmem_address),
    .pmem_wdata   (pmem_wdata),
    .pmem_wmask   (pmem_wmask),
    .pmem_resp    (pmem_resp),
    .pmem_rdata   (pmem_rdata)
`ifdef MEM_ARB_PERF_EN
    ,
    .perf_imem_wait (perf_imem_wait),
    .perf_dmem_wait (perf_dmem_wait)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // One complete transaction starting from the current (IDLE) cycle, where requests are already driven.
  task automatic run_txn(input int delay, input bit drop, input logic [31:0] rd);
    bit          ir, dr, win_d, exp_wr;
    logic [31:0] e_addr, e_wdata;
    logic [3:0]  e_mask;
    ir      = imem_read;
    dr      = dmem_read | dmem_write;
    win_d   = (ir && dr) ? !last_d : dr;
    exp_wr  = win_d && dmem_write;
    e_addr  = win_d ? dmem_address : imem_address;
    e_mask  = exp_wr ? dmem_wmask : 4'hF;
    e_wdata = dmem_wdata;
    @(posedge clk); #1;
    chk1("strobe_read", pmem_read, !exp_wr);
    chk1("strobe_write", pmem_write, exp_wr);
    chk("pmem_address", pmem_address, e_addr);
    chk("pmem_wmask", {28'd0, pmem_wmask}, {28'd0, e_mask});
    if (exp_wr) chk("pmem_wdata", pmem_wdata, e_wdata);
    for (int c = 0; c < delay; c++) begin
      if (win_d) begin
        dmem_address = $urandom;
        if (drop) begin dmem_read = 1'b0; dmem_write = 1'b0; end
      end else begin
        imem_address = $urandom;
        if (drop) imem_read = 1'b0;
      end
      @(posedge clk); #1;
      chk("hold_address", pmem_address, e_addr);
      chk1("hold_strobe", pmem_read | pmem_write, 1'b1);
    end
    pmem_resp  = 1'b1;
    pmem_rdata = rd;
    @(posedge clk); #1;
    pmem_resp  = 1'b0;
    pmem_rdata = $urandom;
    if (!exp_wr) begin
      if (win_d) exp_drdata = rd;
      else       exp_irdata = rd;
    end
    last_d = win_d;
    chk1("imem_resp", imem_resp, !win_d);
    chk1("dmem_resp", dmem_resp, win_d);
    if (win_d) chk("dmem_rdata", dmem_rdata, exp_drdata);
    else       chk("imem_rdata", imem_rdata, exp_irdata);
    chk1("resp_no_strobe", pmem_read | pmem_write, 1'b0);
    @(posedge clk); #1;
    chk1("resp_pulse_end", imem_resp | dmem_resp, 1'b0);
    chk1("idle_no_strobe", pmem_read | pmem_write, 1'b0);
    if (win_d) begin dmem_read = 1'b0; dmem_write = 1'b0; end
    else imem_read = 1'b0;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    imem_read = 1'b0; dmem_read = 1'b0; dmem_write = 1'b0; pmem_resp = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    last_d = 1'b0;
    exp_irdata = 32'd0;
    exp_drdata = 32'd0;
  endtask

  initial begin
    int op;
    rst = 1'b1;
    imem_read = 1'b0; imem_address = 32'd0;
    dmem_read = 1'b0; dmem_write = 1'b0; dmem_wmask = 4'd0;
    dmem_address = 32'd0; dmem_wdata = 32'd0;
    pmem_resp = 1'b0; pmem_rdata = 32'd0;

    // Reset values
    apply_reset();
    chk1("rst_imem_resp", imem_resp, 1'b0);
    chk1("rst_dmem_resp", dmem_resp, 1'b0);
    chk("rst_imem_rdata", imem_rdata, 32'd0);
    chk("rst_dmem_rdata", dmem_rdata, 32'd0);
    chk1("rst_pmem_read", pmem_read, 1'b0);
    chk1("rst_pmem_write", pmem_write, 1'b0);
    chk("rst_pmem_address", pmem_address, 32'd0);
    chk("rst_pmem_wdata", pmem_wdata, 32'd0);
    chk("rst_pmem_wmask", {28'd0, pmem_wmask}, 32'd0);

    // First tie after reset: dmem first, then the held imem request
    imem_read = 1'b1; imem_address = 32'h0000_0200;
    dmem_read = 1'b1; dmem_address = 32'h0000_0300;
    run_txn(1, 1'b0, 32'h1111_2222);
    run_txn(0, 1'b0, 32'h3333_4444);

    // Lone fetch at 0x60, pmem_resp two cycles after the strobe
    imem_read = 1'b1; imem_address = 32'h0000_0060;
    run_txn(2, 1'b0, 32'h0000_0013);

    // Masked store; dmem_rdata must keep the previous load data
    dmem_write = 1'b1; dmem_address = 32'h0000_0100;
    dmem_wmask = 4'b0011; dmem_wdata = 32'hDEAD_BEEF;
    run_txn(1, 1'b0, 32'hCAFE_F00D);

    // Both ports held continuously for six grants: must alternate
    imem_read = 1'b1; imem_address = 32'h0000_1000;
    dmem_read = 1'b1; dmem_address = 32'h0000_2000;
    for (int t = 0; t < 6; t++) begin
      run_txn($urandom_range(0, 2), 1'b0, $urandom);
      if (last_d) begin dmem_read = 1'b1; dmem_address = 32'h0000_2000 + 32'(t * 4); end
      else begin imem_read = 1'b1; imem_address = 32'h0000_1000 + 32'(t * 4); end
    end
    imem_read = 1'b0; dmem_read = 1'b0; dmem_write = 1'b0;

    // Randomized rounds
    for (int r = 0; r < 40; r++) begin
      if (!imem_read && ($urandom_range(0, 1) == 1)) begin
        imem_read = 1'b1; imem_address = $urandom & 32'hFFFF_FFFC;
      end
      if (!(dmem_read || dmem_write) && ($urandom_range(0, 1) == 1)) begin
        op = $urandom_range(0, 2);
        dmem_read  = (op != 1);
        dmem_write = (op != 0);
        dmem_address = $urandom & 32'hFFFF_FFFC;
        dmem_wdata = $urandom;
        dmem_wmask = 4'($urandom_range(0, 15));
      end
      if (!imem_read && !(dmem_read || dmem_write)) begin
        imem_read = 1'b1; imem_address = $urandom & 32'hFFFF_FFFC;
      end
      run_txn($urandom_range(0, 3), ($urandom_range(0, 1) == 1), $urandom);
    end
    imem_read = 1'b0; dmem_read = 1'b0; dmem_write = 1'b0;

    // Reset in the middle of BUSY, then a stray pmem_resp
    @(posedge clk); #1;
    imem_read = 1'b1; imem_address = 32'h0000_0440;
    @(posedge clk); #1;
    chk1("busy_strobe", pmem_read, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; imem_read = 1'b0;
    last_d = 1'b0; exp_irdata = 32'd0; exp_drdata = 32'd0;
    chk1("midrst_pmem_read", pmem_read, 1'b0);
    chk1("midrst_resps", imem_resp | dmem_resp, 1'b0);
    chk("midrst_imem_rdata", imem_rdata, 32'd0);
    pmem_resp = 1'b1; pmem_rdata = 32'h5A5A_5A5A;
    @(posedge clk); #1;
    pmem_resp = 1'b0;
    chk1("stray_resp_imem", imem_resp, 1'b0);
    chk1("stray_resp_dmem", dmem_resp, 1'b0);
    @(posedge clk); #1;
    chk1("stray_resp_late", imem_resp | dmem_resp, 1'b0);
    chk1("stray_no_strobe", pmem_read | pmem_write, 1'b0);
    chk("stray_imem_rdata", imem_rdata, 32'd0);
    imem_read = 1'b1; imem_address = 32'h0000_0440;
    dmem_read = 1'b1; dmem_address = 32'h0000_0880;
    run_txn(0, 1'b0, 32'h0BAD_CAFE);
    run_txn(1, 1'b0, 32'h1234_5678);

`ifdef MEM_ARB_PERF_EN
    // imem held five cycles before its resp pulse
    apply_reset();
    imem_read = 1'b1; imem_address = 32'h0000_0060;
    run_txn(3, 1'b0, 32'h0000_0013);
    chk("perf_imem_wait", perf_imem_wait, 32'd5);
    chk("perf_dmem_wait", perf_dmem_wait, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
